// File: rtl/garage_door_controller.sv
// Garage door motor sequencer: button merge, limit stop, obstruction
// auto-reverse, reversal dead time and travel-timeout fault latch.
module garage_door_controller #(
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int DEADTIME_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       activate,
  input  logic       inside_up_button,
  input  logic       outside_up_button,
  input  logic       inside_down_button,
  input  logic       outside_down_button,
  input  logic       up_limit,
  input  logic       down_limit,
  input  logic       obstruction,
  output logic       motor_up,
  output logic       motor_down,
  output logic [2:0] door_state,
  output logic       fault
);

  typedef enum logic [2:0] {
    STOPPED  = 3'd0,
    OPENING  = 3'd1,
    CLOSING  = 3'd2,
    OPEN     = 3'd3,
    CLOSED   = 3'd4,
    DEADTIME = 3'd5,
    FAULT    = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DT_LAST = CNT_W'(DEADTIME_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           nxt;
  logic             pend_dir;
  logic             nxt_pend;
  logic [CNT_W-1:0] cnt;
  logic             up_req;
  logic             down_req;
  logic             stop;
  logic             timing;

  assign up_req   = activate & (inside_up_button | outside_up_button);
  assign down_req = activate & (inside_down_button | outside_down_button);
  assign stop     = !activate | (up_req & down_req);
  assign timing   = (state == OPENING) | (state == CLOSING) |
                    (state == DEADTIME);

  always_comb begin
    nxt      = state;
    nxt_pend = pend_dir;
    // Both limits at once means a broken sensor: latch a fault.
    if (state != FAULT && up_limit && down_limit) begin
      nxt = FAULT;
    end else begin
      case (state)
        STOPPED, OPEN, CLOSED: begin
          if (stop)
            nxt = STOPPED;
          else if (up_req && !up_limit)
            nxt = OPENING;
          else if (down_req && !down_limit && !obstruction)
            nxt = CLOSING;
          else if (up_limit)
            nxt = OPEN;
          else if (down_limit)
            nxt = CLOSED;
          else
            nxt = STOPPED;
        end
        OPENING: begin
          if (stop)
            nxt = STOPPED;
          else if (up_limit)
            nxt = OPEN;
          else if (cnt == TO_LAST)
            nxt = FAULT;
          else if (down_req) begin
            nxt      = DEADTIME;
            nxt_pend = 1'b1;
          end
        end
        CLOSING: begin
          if (stop)
            nxt = STOPPED;
          else if (down_limit)
            nxt = CLOSED;
          else if (obstruction) begin
            nxt      = DEADTIME;
            nxt_pend = 1'b0;
          end else if (cnt == TO_LAST)
            nxt = FAULT;
          else if (up_req) begin
            nxt      = DEADTIME;
            nxt_pend = 1'b0;
          end
        end
        DEADTIME: begin
          if (stop)
            nxt = STOPPED;
          else if (cnt == DT_LAST) begin
            if (!pend_dir)
              nxt = OPENING;
            else if (!obstruction)
              nxt = CLOSING;
            else
              nxt = STOPPED;
          end
        end
        FAULT: begin
          if (!activate)
            nxt = STOPPED;
        end
        default: nxt = STOPPED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= STOPPED;
      pend_dir   <= 1'b0;
      cnt        <= '0;
      motor_up   <= 1'b0;
      motor_down <= 1'b0;
      door_state <= 3'd0;
      fault      <= 1'b0;
    end else begin
      state    <= nxt;
      pend_dir <= nxt_pend;
      if (nxt != state)
        cnt <= '0;
      else if (timing && cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
      // Outputs decode the next state so they line up with it.
      motor_up   <= (nxt == OPENING);
      motor_down <= (nxt == CLOSING);
      door_state <= nxt;
      fault      <= (nxt == FAULT);
    end
  end

endmodule
